// File: rtl/store_align_unit.sv
// store_align_unit
// Store-path aligner between the EX/MEM register and the data SRAM write port.
// Takes SB/SH/SW requests, moves the store data onto byte lanes and builds
// active-low byte write enables. A store that crosses a word boundary goes
// out as two back-to-back word beats.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   core-side handshake (ready only while idle)
//   req_funct3            000 SB, 001 SH, 010 SW, anything else is illegal
//   req_addr, req_data    byte address and rs2 value
//   mem_cs/mem_ready      write-beat handshake to the data memory
//   mem_addr              word address of the beat ([1:0] = 0)
//   mem_web               active-low byte enables, bit i = lane i
//   mem_di                lane-aligned write data
//   done, err             one-cycle completion pulse; err marks an illegal funct3

// One byte lane of the 8-lane (two-word) shifted store image.
// Lane LANE receives source byte j when off + j == LANE. Bytes outside the
// access size are zeroed so the unused lanes of mem_di are deterministic.
module store_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  off,
  input  logic [3:0]  size_mask,
  input  logic [31:0] data,
  output logic        we,
  output logic [7:0]  byte_o
);
  always_comb begin
    we     = 1'b0;
    byte_o = 8'h00;
    for (int j = 0; j < 4; j++) begin
      if (int'(off) + j == LANE) begin
        we     = size_mask[j];
        byte_o = size_mask[j] ? data[8*j +: 8] : 8'h00;
      end
    end
  end
endmodule

module store_align_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_cs,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_web,
  output logic [31:0] mem_di,
  input  logic        mem_ready,
  output logic        done,
  output logic        err
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, ERR} state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
  } store_req_t;

  state_t     state, state_nxt;
  store_req_t req_q;

  logic [3:0]                  size_mask;
  logic                        legal;
  logic [NUM_LANES-1:0]        lane_we;
  logic [NUM_LANES-1:0][7:0]   lane_byte;
  logic [31:0]                 word_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      // Request fields are captured once; later changes on the bus are ignored.
      if (state == IDLE && req_valid)
        req_q <= '{funct3: req_funct3, addr: req_addr, data: req_data};
    end
  end

  assign legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                 (req_funct3 == 3'b010);

  always_comb begin
    case (req_q.funct3)
      3'b000:  size_mask = 4'b0001;
      3'b001:  size_mask = 4'b0011;
      3'b010:  size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  // Lanes 0..3 form the first word, lanes 4..7 the spill into the next word.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    store_lane #(.LANE(i)) u_lane (
      .off       (req_q.addr[1:0]),
      .size_mask (size_mask),
      .data      (req_q.data),
      .we        (lane_we[i]),
      .byte_o    (lane_byte[i])
    );
  end

  assign word_addr = {req_q.addr[31:2], 2'b00};

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_cs    = 1'b0;
    mem_addr  = '0;
    mem_web   = 4'b1111;
    mem_di    = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = legal ? BEAT1 : ERR;
      end
      BEAT1: begin
        mem_cs   = 1'b1;
        mem_addr = word_addr;
        mem_web  = ~lane_we[3:0];
        mem_di   = lane_byte[3:0];
        if (mem_ready) begin
          if (|lane_we[7:4]) begin
            state_nxt = BEAT2;
          end else begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      BEAT2: begin
        mem_cs   = 1'b1;
        mem_addr = word_addr + 32'd4;   // wraps past the top of memory
        mem_web  = ~lane_we[7:4];
        mem_di   = lane_byte[7:4];
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_cs;
  logic [31:0] mem_addr;
  logic [3:0]  mem_web;
  logic [31:0] mem_di;
  logic        mem_ready;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  store_align_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_web(mem_web), .mem_di(mem_di),
    .mem_ready(mem_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".cs"},    32'(mem_cs),    32'd0);
    chk({tag, ".web"},   32'(mem_web),   32'hF);
    chk({tag, ".addr"},  mem_addr,       32'd0);
    chk({tag, ".di"},    mem_di,         32'd0);
    chk({tag, ".done"},  32'(done),      32'd0);
    chk({tag, ".err"},   32'(err),       32'd0);
  endtask

  // Reference: place each stored byte k at absolute byte position off+k of a
  // two-word window; position/4 picks the beat, position%4 the lane.
  task automatic run_req(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int stall);
    logic [31:0] e_addr [2];
    logic [31:0] e_di   [2];
    logic [3:0]  e_web  [2];
    logic [31:0] w;
    logic [3:0]  wb;
    int size, off, nb, p, s;
    bit legal;
    legal = (f3 <= 3'd2);
    size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    off   = int'(a[1:0]);
    nb    = (off + size - 1) / 4 + 1;
    e_addr[0] = a & 32'hFFFF_FFFC;
    e_addr[1] = e_addr[0] + 32'd4;
    for (int b = 0; b < 2; b++) begin e_di[b] = '0; e_web[b] = 4'hF; end
    for (int k = 0; k < size; k++) begin
      p  = off + k;
      w  = e_di[p/4];
      wb = e_web[p/4];
      w[8*(p%4) +: 8] = d[8*k +: 8];
      wb[p%4] = 1'b0;
      e_di[p/4]  = w;
      e_web[p/4] = wb;
    end

    chk_idle({tag, ".pre"});
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_data = d;
    @(negedge clk);
    // Scramble the request bus: the unit must be using its captured copy.
    req_valid = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_data = $urandom;
    if (!legal) begin
      mem_ready = 1'($urandom);
      #1;
      chk({tag, ".e.done"},  32'(done),      32'd1);
      chk({tag, ".e.err"},   32'(err),       32'd1);
      chk({tag, ".e.cs"},    32'(mem_cs),    32'd0);
      chk({tag, ".e.web"},   32'(mem_web),   32'hF);
      chk({tag, ".e.ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end else begin
      for (int b = 0; b < nb; b++) begin
        s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int c = 0; c <= s; c++) begin
          mem_ready = (c == s);
          #1;
          chk({tag, ".cs"},    32'(mem_cs),    32'd1);
          chk({tag, ".addr"},  mem_addr,       e_addr[b]);
          chk({tag, ".web"},   32'(mem_web),   32'(e_web[b]));
          chk({tag, ".di"},    mem_di,         e_di[b]);
          chk({tag, ".ready"}, 32'(req_ready), 32'd0);
          chk({tag, ".err"},   32'(err),       32'd0);
          chk({tag, ".done"},  32'(done),      32'((c == s) && (b == nb - 1)));
          @(negedge clk);
        end
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'($urandom);
  endtask

  initial begin
    logic [2:0] f3;
    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_data = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    run_req("sb_plan",  3'b000, 32'h1000_0002, 32'hDEAD_BEEF, 0);
    run_req("sw_split", 3'b010, 32'h2000_0001, 32'h1122_3344, 0);
    run_req("sh_wrap",  3'b001, 32'hFFFF_FFFF, 32'h0000_ABCD, 0);
    run_req("sw_stall", 3'b010, 32'h3000_0008, 32'h5566_7788, 3);
    run_req("illegal",  3'b011, 32'h0000_0010, 32'h1234_5678, 0);
    run_req("sh_off2",  3'b001, 32'h0000_0106, 32'hFFFF_1234, 1);
    run_req("sw_off3",  3'b010, 32'h0000_0203, 32'hA1B2_C3D4, 2);

    // Reset in the middle of the second beat of a split SW.
    chk_idle("rst.pre");
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4000_0002;
    req_data = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    #1 chk("rst.beat1.cs", 32'(mem_cs), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("rst.beat2.addr", mem_addr, 32'h4000_0004);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1 chk_idle("rst.post");
    run_req("sb_after_rst", 3'b000, 32'h0000_0001, 32'h0000_0055, 0);

    for (int i = 0; i < 150; i++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      run_req("rand", f3, $urandom, $urandom, -1);
    end
    chk_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
